// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - shared opcodes and parity helper for the gate array pipeline
package gate_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_XNOR = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_NOTA = 3'd6;
  localparam logic [2:0] OP_BUF  = 3'd7;

  // Widest operand the parity helper accepts; callers zero-extend into it,
  // which leaves the XOR reduction unchanged.
  localparam int PAR_MAX_W = 256;

  function automatic logic parity(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/gate_alu.sv
// rtl/gate_alu.sv - combinational bitwise gate selector with operand equality flag
module gate_alu
  import gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y,
  output logic             eq
);

  // Select one of eight bitwise operations; NOT A and BUF A ignore b.
  always_comb begin
    y  = a;
    eq = &(~(a ^ b));
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_NOTA: y = ~a;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/gate_array_pipe.sv
// rtl/gate_array_pipe.sv - two-stage valid/ready gate array with saturating equality counter
module gate_array_pipe
  import gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_eq,
  output logic             out_par,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] eq_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [2:0]       s1_op_q, s1_op_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_y_q, out_y_d;
  logic             out_eq_q, out_eq_d;
  logic             out_par_q, out_par_d;
  logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;

  logic             s2_load;
  logic             in_hs;
  logic             out_hs;
  logic [WIDTH-1:0] alu_y;
  logic             alu_eq;
  logic [PAR_MAX_W-1:0] alu_y_ext;

  gate_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a  (s1_a_q),
    .b  (s1_b_q),
    .op (s1_op_q),
    .y  (alu_y),
    .eq (alu_eq)
  );

  // Handshakes: S2 refills whenever it is empty or being drained this cycle.
  always_comb begin
    out_hs   = out_valid_q && out_ready;
    s2_load  = s1_valid_q && (!out_valid_q || out_ready);
    in_ready = !s1_valid_q || s2_load;
    in_hs    = in_valid && in_ready;
  end

  // Stage 1 captures operands on an input handshake and empties when it hands off.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    if (in_hs) begin
      s1_valid_d = 1'b1;
      s1_a_d     = in_a;
      s1_b_d     = in_b;
      s1_op_d    = in_op;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2 registers the result; contents hold while the beat waits for out_ready.
  always_comb begin
    alu_y_ext              = '0;
    alu_y_ext[WIDTH-1:0]   = alu_y;
    out_valid_d            = out_valid_q;
    out_y_d                = out_y_q;
    out_eq_d               = out_eq_q;
    out_par_d              = out_par_q;
    if (s2_load) begin
      out_valid_d = 1'b1;
      out_y_d     = alu_y;
      out_eq_d    = alu_eq;
      out_par_d   = parity(alu_y_ext);
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end
  end

  // Count delivered equal-operand results, saturating; clear wins over increment.
  always_comb begin
    eq_cnt_d = eq_cnt_q;
    if (cnt_clr) begin
      eq_cnt_d = '0;
    end else if (out_hs && out_eq_q && (eq_cnt_q != CNT_MAX)) begin
      eq_cnt_d = eq_cnt_q + CNT_W'(1);
    end
  end

  // All pipeline and counter state, emptied asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_eq_q    <= 1'b0;
      out_par_q   <= 1'b0;
      eq_cnt_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_op_q     <= s1_op_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_eq_q    <= out_eq_d;
      out_par_q   <= out_par_d;
      eq_cnt_q    <= eq_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_eq    = out_eq_q;
  assign out_par   = out_par_q;
  assign eq_cnt    = eq_cnt_q;

endmodule

// File: tb/tb_gate_array_pipe.sv
// tb/tb_gate_array_pipe.sv - self-checking bench for gate_array_pipe
module tb_gate_array_pipe;

  localparam int W  = 8;
  localparam int CW = 2;
  localparam int CNT_SAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in_a, in_b, out_y;
  logic [2:0]    in_op;
  logic          out_eq, out_par, cnt_clr;
  logic [CW-1:0] eq_cnt;

  logic          w1_in_valid, w1_in_ready, w1_out_valid, w1_out_ready;
  logic [0:0]    w1_in_a, w1_in_b, w1_out_y;
  logic [2:0]    w1_in_op;
  logic          w1_out_eq, w1_out_par, w1_cnt_clr;
  logic [7:0]    w1_eq_cnt;

  gate_array_pipe #(.WIDTH(W), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_eq(out_eq), .out_par(out_par),
    .cnt_clr(cnt_clr), .eq_cnt(eq_cnt)
  );

  gate_array_pipe #(.WIDTH(1), .CNT_W(8)) u_w1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(w1_in_valid), .in_ready(w1_in_ready),
    .in_a(w1_in_a), .in_b(w1_in_b), .in_op(w1_in_op),
    .out_valid(w1_out_valid), .out_ready(w1_out_ready),
    .out_y(w1_out_y), .out_eq(w1_out_eq), .out_par(w1_out_par),
    .cnt_clr(w1_cnt_clr), .eq_cnt(w1_eq_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the opcode table evaluated directly on whole operands.
  function automatic logic [W-1:0] ref_y(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] op);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a ^ b);
      3'd4:    return ~(a & b);
      3'd5:    return ~(a | b);
      3'd6:    return ~a;
      default: return a;
    endcase
  endfunction

  typedef struct {
    logic [W-1:0] y;
    logic         eq;
    logic         par;
    int           stamp;
  } beat_t;

  beat_t        sb[$];
  logic [W-1:0] delivered[$];
  int           model_cnt = 0;
  int           cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model: beats in flight form a FIFO; a beat becomes visible one edge after acceptance.
  always @(negedge clk) begin
    logic  exp_ready, exp_valid, ohs, ihs;
    beat_t nb;
    if (rst_n) begin
      exp_ready = (sb.size() < 2) || out_ready;
      exp_valid = (sb.size() > 0) && ((cyc - sb[0].stamp) >= 1);
      chk("in_ready", in_ready, exp_ready);
      chk("out_valid", out_valid, exp_valid);
      if (exp_valid && out_valid) begin
        chk("out_y", out_y, sb[0].y);
        chk("out_eq", out_eq, sb[0].eq);
        chk("out_par", out_par, sb[0].par);
      end
      chk("eq_cnt", eq_cnt, model_cnt);
      ohs = exp_valid && out_ready;
      ihs = in_valid && exp_ready;
      if (cnt_clr) model_cnt = 0;
      else if (ohs && sb[0].eq && model_cnt < CNT_SAT) model_cnt++;
      if (ohs) begin
        delivered.push_back(sb[0].y);
        void'(sb.pop_front());
      end
      if (ihs) begin
        nb.y     = ref_y(in_a, in_b, in_op);
        nb.eq    = (in_a == in_b);
        nb.par   = ($countones(nb.y) % 2) == 1;
        nb.stamp = cyc + 1;
        sb.push_back(nb);
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                      output int tries);
    logic hs;
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    tries = 0;
    do begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      tries++;
    end while (!hs && tries < 200);
    if (!hs) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] sweep_exp [8];
  logic [3:0]   xor_tt;
  logic [1:0]   cnt_exp [5];
  logic [1:0]   cnt_got;
  logic         tt_bit;
  int           tries;
  int           base;

  initial begin
    sweep_exp = '{8'hC0, 8'hFC, 8'h3C, 8'hC3, 8'h3F, 8'h03, 8'h0F, 8'hF0};
    cnt_exp   = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd0};
    xor_tt    = 4'b0110;
    rst_n = 1'b0;
    in_valid = 0; in_a = 0; in_b = 0; in_op = 0; out_ready = 0; cnt_clr = 0;
    w1_in_valid = 0; w1_in_a = 0; w1_in_b = 0; w1_in_op = 0; w1_out_ready = 1; w1_cnt_clr = 0;

    // Reset values
    repeat (2) @(posedge clk);
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_eq", out_eq, 0);
    chk("rst_out_par", out_par, 0);
    chk("rst_eq_cnt", eq_cnt, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Single XNOR beat, 2-cycle latency
    send(8'hA5, 8'h5A, 3'd3, tries);
    @(posedge clk);
    #1;
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_y", out_y, 8'h00);
    chk("t1_out_eq", out_eq, 0);
    chk("t1_out_par", out_par, 0);
    chk("t1_eq_cnt", eq_cnt, 0);
    drain();

    // Opcode sweep, back-to-back
    delivered.delete();
    for (int op = 0; op < 8; op++) begin
      send(8'hF0, 8'hCC, 3'(op), tries);
      chk("t2_one_try", tries, 1);
    end
    drain();
    chk("t2_count", delivered.size(), 8);
    for (int i = 0; i < 8 && i < delivered.size(); i++) chk("t2_sweep_y", delivered[i], sweep_exp[i]);

    // Backpressure: two held, third stalls until release
    delivered.delete();
    out_ready = 1'b0;
    send(8'h11, 8'h22, 3'd1, tries);
    send(8'h0F, 8'hFF, 3'd0, tries);
    in_a = 8'hAA; in_b = 8'h55; in_op = 3'd2; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("t3_in_ready_low", in_ready, 0);
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_y", out_y, 8'h33);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("t3_in_ready_release", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();
    chk("t3_count", delivered.size(), 3);
    if (delivered.size() == 3) begin
      chk("t3_y0", delivered[0], 8'h33);
      chk("t3_y1", delivered[1], 8'h0F);
      chk("t3_y2", delivered[2], 8'hFF);
    end

    // Equality counter with saturation and clear-priority
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      send(8'h3C, 8'h3C, 3'd0, tries);
      @(posedge clk);
      #1;
      chk("t4_out_valid", out_valid, 1);
      chk("t4_out_eq", out_eq, 1);
      cnt_clr = (k == 4);
      @(posedge clk);
      #1;
      cnt_clr = 1'b0;
      cnt_got = eq_cnt;
      chk("t4_eq_cnt", cnt_got, cnt_exp[k]);
    end
    drain();

    // Asynchronous reset with both stages full
    send(8'h77, 8'h77, 3'd7, tries);
    drain();
    out_ready = 1'b0;
    send(8'h01, 8'h01, 3'd1, tries);
    send(8'h02, 8'h03, 3'd2, tries);
    @(negedge clk);
    #2;
    chk("t5_pre_valid", out_valid, 1);
    chk("t5_pre_cnt", eq_cnt, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", out_valid, 0);
    chk("t5_async_cnt", eq_cnt, 0);
    sb.delete();
    model_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      #1;
      chk("t5_no_stale", out_valid, 0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom % 4) != 0;
      in_a      = W'($urandom);
      in_b      = (($urandom % 4) == 0) ? in_a : W'($urandom);
      in_op     = 3'($urandom);
      out_ready = ($urandom % 3) != 0;
      cnt_clr   = ($urandom % 40) == 0;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    drain();

    // WIDTH=1 truth tables for XOR and XNOR
    base = 0;
    for (int op = 2; op <= 3; op++) begin
      for (int ab = 0; ab < 4; ab++) begin
        @(posedge clk);
        #1;
        w1_in_a = 1'(ab >> 1); w1_in_b = 1'(ab); w1_in_op = 3'(op); w1_in_valid = 1'b1;
        @(posedge clk);
        #1;
        w1_in_valid = 1'b0;
        @(posedge clk);
        #1;
        tt_bit = xor_tt[ab];
        if (op == 3) tt_bit = ~tt_bit;
        chk("w1_valid", w1_out_valid, 1);
        chk("w1_y", w1_out_y, tt_bit);
        chk("w1_par", w1_out_par, tt_bit);
        chk("w1_eq", w1_out_eq, (ab == 0 || ab == 3));
        if (ab == 0 || ab == 3) base++;
      end
    end
    @(posedge clk);
    #1;
    chk("w1_eq_cnt", w1_eq_cnt, base);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_array_pipe.md
Name: gate_array_pipe

Overview:
- Parametrised, pipelined successor to the single-bit gate primitives: applies one of eight selectable bitwise logic operations across a WIDTH-bit operand pair.
- Produces the result, an operand-equality flag (XNOR reduction) and the result's parity.
- Uses valid/ready handshakes on both sides with a fixed 2-cycle latency.
- Keeps a saturating count of delivered results whose operands were equal; it sits between stimulus sources and checkers in the lab logic datapath.

Parameters:
- WIDTH, 8, operand/result bit width (>=1).
- CNT_W, 8, width of the equality event counter (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block can accept input this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  3  operation select.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts result.
- out_y  output  WIDTH  bitwise result.
- out_eq  output  1  1 when captured A == B.
- out_par  output  1  XOR-reduction of out_y.
- cnt_clr  input  1  synchronous clear of eq_cnt.
- eq_cnt  output  CNT_W  saturating count of accepted results with out_eq=1.

Behaviour:
- Single clock domain, clk; reset is rst_n, asynchronous, active-low.
- Reset values: all stage valids 0, out_valid=0, out_y=0, out_eq=0, out_par=0, eq_cnt=0. in_ready=1 one cycle after reset deassertion.
- Opcodes:
  - 0 AND, 1 OR, 2 XOR, 3 XNOR, 4 NAND, 5 NOR
  - 6 NOT A (in_b ignored)
  - 7 BUF A (in_b ignored)
- Stage 1 (S1) registers in_a, in_b, in_op on an input handshake (in_valid && in_ready).
- Stage 2 (S2) registers the gate result, eq = &(~(a^b)) and par = ^y computed from S1 contents. S2 drives the out_* ports directly from registers; no combinational path from in_* to out_*.
- Latency: a beat accepted at edge N is presented with out_valid=1 after edge N+1 (2 registered stages), provided out_ready was held high.
- Advance rules:
  - S2 loads when S1 is valid and (S2 empty or out_ready).
  - S1 loads on an input handshake.
  - in_ready = !s1_valid || s2_load.
- Throughput: 1 beat/cycle with out_ready held high.
- Backpressure:
  - With out_ready=0, at most 2 beats are held (S1 + S2); in_ready falls only when both stages are full.
  - out_y/out_eq/out_par are stable while out_valid=1 and out_ready=0.
  - Beats are never dropped, duplicated or reordered.
- Simultaneous events: with both stages full and out_ready=1, the S2 output is consumed, S1 moves to S2 and a new input is accepted in the same cycle.
- Counter:
  - eq_cnt increments on each output handshake (out_valid && out_ready) with out_eq=1.
  - Saturates at 2^CNT_W-1; no wrap.
  - cnt_clr has priority: when cnt_clr=1 and an increment occur in the same cycle, eq_cnt becomes 0.
- Reset mid-operation: rst_n low asynchronously empties both stages and clears the counter. In-flight beats are discarded; the pipeline restarts from the empty state.
- Width rules: all logic is purely bitwise over WIDTH; WIDTH=1 degenerates to the single-gate case with out_par=out_y.

Decomposition:
- Shared package gate_pkg:
  - opcode localparams OP_AND..OP_BUF (3-bit).
  - a function for the parity reduction.
- One natural sub-module: gate_alu (combinational, parametrised WIDTH; inputs a, b, op; outputs y, eq). Instantiated between S1 and S2.
- Pipeline control and counter stay in the top-level module.

Test Plan:
1. Reset, then a single beat (WIDTH=8): A=0xA5, B=0x5A, op=3 (XNOR), out_ready=1 -> 2 cycles later out_valid=1, out_y=0x00, out_eq=0, out_par=0, eq_cnt=0.
2. Opcode sweep with A=0xF0, B=0xCC, back-to-back beats, out_ready=1 -> out_y sequence 0xC0, 0xFC, 0x3C, 0xC3, 0x3F, 0x03, 0x0F, 0xF0; one result per cycle; in_ready stays 1.
3. Backpressure: out_ready=0, 3 beats offered -> 2 accepted, then in_ready=0 and out_y holds the first result. Release out_ready -> all 3 delivered in order with none lost.
4. Equality and counter, CNT_W=2:
   - 5 beats with A=B=0x3C, op=0 -> out_eq=1 each; eq_cnt goes 1, 2, 3, 3 (saturated).
   - cnt_clr on the 5th handshake -> eq_cnt=0.
5. Async reset: drop rst_n while both stages are full and out_ready=0 -> out_valid=0 and eq_cnt=0 immediately, without waiting for a clock edge; no stale beat appears after reset release.
6. WIDTH=1 build: exhaustive a, b over ops 2 and 3 -> XOR/XNOR truth tables match, with out_par=out_y.
